// File: rtl/fifo_read_control_pkg.sv
// Shared helpers for the async FIFO pointer controllers (read and write side).
package fifo_read_control_pkg;

  localparam int unsigned ADDRESS_SIZE_DEFAULT = 3;

  // Widest pointer the Gray helpers handle; callers zero-extend and truncate,
  // which is exact because leading zeros do not change either conversion.
  localparam int unsigned GRAY_MAX_W = 16;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_width(input int unsigned asize);
    return asize + 1;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_read_control_if.sv
// Read-side handshake and status bundle between FIFO read controller and consumer.
interface fifo_read_control_if
  import fifo_read_control_pkg::*;
#(
  parameter int unsigned address_size = ADDRESS_SIZE_DEFAULT
);

  localparam int unsigned PTR_W = ptr_width(address_size);

  logic                    read_increment;
  logic [PTR_W-1:0]        write_pointer;
  logic [address_size-1:0] read_address;
  logic [PTR_W-1:0]        read_pointer;
  logic                    read_empty;
  logic                    read_almost_empty;
  logic [PTR_W-1:0]        read_count;

  // Controller side.
  modport slave (
    input  read_increment, write_pointer,
    output read_address, read_pointer, read_empty, read_almost_empty, read_count
  );

  // Consumer / write-domain side.
  modport master (
    output read_increment, write_pointer,
    input  read_address, read_pointer, read_empty, read_almost_empty, read_count
  );

endinterface

// File: rtl/fifo_read_control_sync_write_to_read.sv
// Two-flop synchronizer bringing the Gray write pointer into the read clock domain.
module sync_write_to_read #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             read_clk,
  input  logic             read_reset,
  input  logic [WIDTH-1:0] i_write_pointer,
  output logic [WIDTH-1:0] o_wq2
);

  logic [WIDTH-1:0] r_wq1;
  logic [WIDTH-1:0] r_wq2;

  // Plain flop-to-flop chain; nothing may sit between the two stages.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= i_write_pointer;
      r_wq2 <= r_wq1;
    end
  end

  assign o_wq2 = r_wq2;

endmodule

// File: rtl/fifo_read_control.sv
// Read-side pointer, empty/almost-empty and fill-count controller of the async FIFO.
module fifo_read_control
  import fifo_read_control_pkg::*;
#(
  parameter int unsigned address_size       = ADDRESS_SIZE_DEFAULT,
  parameter int unsigned almost_empty_level = 1
) (
  input  logic               read_clk,
  input  logic               read_reset,
  fifo_read_control_if.slave bus
);

  localparam int unsigned PTR_W = ptr_width(address_size);

  logic [PTR_W-1:0] r_bin;
  logic [PTR_W-1:0] r_gray;
  logic [PTR_W-1:0] r_count;
  logic             r_empty;
  logic             r_almost_empty;

  logic             w_pop;
  logic [PTR_W-1:0] w_wq2;
  logic [PTR_W-1:0] w_wq2_bin;
  logic [PTR_W-1:0] w_bin_next;
  logic [PTR_W-1:0] w_gray_next;
  logic [PTR_W-1:0] w_count_next;

  sync_write_to_read #(
    .WIDTH (PTR_W)
  ) u_sync_write_to_read (
    .read_clk        (read_clk),
    .read_reset      (read_reset),
    .i_write_pointer (bus.write_pointer),
    .o_wq2           (w_wq2)
  );

  // Next pointer and status, all derived from the same post-pop pointer.
  always_comb begin
    w_pop        = bus.read_increment & ~r_empty;
    w_bin_next   = r_bin + PTR_W'(w_pop);
    w_gray_next  = PTR_W'(bin2gray(GRAY_MAX_W'(w_bin_next)));
    w_wq2_bin    = PTR_W'(gray2bin(GRAY_MAX_W'(w_wq2)));
    w_count_next = w_wq2_bin - w_bin_next;
  end

  // Pointer and status registers; full Gray equality keeps full-depth distinct from empty.
  always_ff @(posedge read_clk or posedge read_reset) begin
    if (read_reset) begin
      r_bin          <= '0;
      r_gray         <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_bin          <= w_bin_next;
      r_gray         <= w_gray_next;
      r_count        <= w_count_next;
      r_empty        <= (w_gray_next == w_wq2);
      r_almost_empty <= (w_count_next <= PTR_W'(almost_empty_level));
    end
  end

  assign bus.read_address      = r_bin[address_size-1:0];
  assign bus.read_pointer      = r_gray;
  assign bus.read_count        = r_count;
  assign bus.read_empty        = r_empty;
  assign bus.read_almost_empty = r_almost_empty;

endmodule

// File: tb/tb_fifo_read_control.sv
// Bench for fifo_read_control: directed vector table, hand sequences, random vs. model.
module tb_fifo_read_control;

  localparam int unsigned AS    = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned PMOD  = 16;
  localparam int unsigned AEL   = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_read_control_if #(.address_size(AS)) bus ();

  fifo_read_control #(
    .address_size       (AS),
    .almost_empty_level (AEL)
  ) dut (
    .read_clk   (clk),
    .read_reset (rst),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          inc;
    int unsigned w;
    int unsigned rd;
    int unsigned cnt;
    bit          e;
    bit          ae;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [3:0] tb_gray(input int unsigned n);
    logic [3:0] b;
    b = 4'(n % PMOD);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int unsigned rd, input int unsigned cnt,
                           input bit e, input bit ae);
    chk({tag, " read_pointer"},      32'(bus.read_pointer),      32'(tb_gray(rd)));
    chk({tag, " read_address"},      32'(bus.read_address),      32'(rd % DEPTH));
    chk({tag, " read_count"},        32'(bus.read_count),        32'(cnt));
    chk({tag, " read_empty"},        32'(bus.read_empty),        32'(e));
    chk({tag, " read_almost_empty"}, 32'(bus.read_almost_empty), 32'(ae));
  endtask

  // Apply inputs on the falling edge, then sample just after the next rising edge.
  task automatic drive(input bit inc, input int unsigned wbin);
    @(negedge clk);
    bus.read_increment = inc;
    bus.write_pointer  = tb_gray(wbin);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit inc, input int unsigned w, input int unsigned rd,
                     input int unsigned cnt, input bit e, input bit ae);
    vec_t v;
    v.inc = inc; v.w = w; v.rd = rd; v.cnt = cnt; v.e = e; v.ae = ae;
    tbl.push_back(v);
  endtask

  int unsigned m_rd, m_w1, m_w2, m_cnt, wcnt;
  bit          m_empty, inc_r;
  int unsigned pop_pct, wr_pct;

  initial begin
    rst                = 1'b1;
    bus.read_increment = 1'b0;
    bus.write_pointer  = '0;
    #3;
    check_all("reset", 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // inc, write count (binary), expected rd, count, empty, almost_empty
    add(0, 1,  0, 0, 1, 1);   // write ptr change seen at edge N: still empty
    add(0, 1,  0, 0, 1, 1);   // edge N+1: still empty
    add(0, 1,  0, 1, 0, 1);   // edge N+2: one entry visible
    add(1, 1,  1, 0, 1, 1);   // pop last entry: empty on same edge
    add(1, 1,  1, 0, 1, 1);   // pop while empty ignored
    add(0, 9,  1, 0, 1, 1);
    add(0, 9,  1, 0, 1, 1);
    add(0, 9,  1, 8, 0, 0);   // full depth, not empty
    add(1, 9,  2, 7, 0, 0);
    add(1, 9,  3, 6, 0, 0);
    add(1, 9,  4, 5, 0, 0);
    add(1, 9,  5, 4, 0, 0);
    add(1, 9,  6, 3, 0, 0);
    add(1, 9,  7, 2, 0, 0);
    add(1, 9,  8, 1, 0, 1);
    add(1, 9,  9, 0, 1, 1);
    add(1, 11, 9, 0, 1, 1);
    add(0, 12, 9, 0, 1, 1);
    add(0, 12, 9, 2, 0, 0);
    add(1, 12, 10, 2, 0, 0);  // pop as synced pointer advances: count holds
    add(1, 12, 11, 1, 0, 1);
    add(1, 12, 12, 0, 1, 1);
    add(0, 0,  12, 0, 1, 1);  // write count wraps to 0
    add(0, 0,  12, 0, 1, 1);
    add(0, 0,  12, 4, 0, 0);
    add(1, 0,  13, 3, 0, 0);
    add(1, 0,  14, 2, 0, 0);
    add(1, 0,  15, 1, 0, 1);
    add(1, 0,  0,  0, 1, 1);  // read pointer wraps to 0000

    foreach (tbl[i]) begin
      drive(tbl[i].inc, tbl[i].w);
      check_all($sformatf("vec%0d", i), tbl[i].rd, tbl[i].cnt, tbl[i].e, tbl[i].ae);
    end

    // Mid-stream asynchronous reset after five pops with three entries left.
    for (int i = 0; i < 3; i++) drive(0, 8);
    for (int i = 0; i < 5; i++) drive(1, 8);
    check_all("pre_reset", 5, 3, 1'b0, 1'b0);
    @(negedge clk);
    bus.read_increment = 1'b0;
    bus.write_pointer  = '0;
    #2;
    rst = 1'b1;
    #1;
    check_all("async_reset", 0, 0, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0);
      check_all($sformatf("post_reset%0d", i), 0, 0, 1'b1, 1'b1);
    end

    // Randomized traffic against a write-count/read-count model with two-edge sync lag.
    m_rd = 0; m_w1 = 0; m_w2 = 0; m_empty = 1'b1; wcnt = 0;
    pop_pct = 50; wr_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) begin
        pop_pct = $urandom_range(10, 90);
        wr_pct  = $urandom_range(10, 90);
      end
      inc_r = ($urandom_range(0, 99) < pop_pct);
      if (((wcnt + PMOD - m_rd) % PMOD) < DEPTH && $urandom_range(0, 99) < wr_pct)
        wcnt = (wcnt + 1) % PMOD;
      drive(inc_r, wcnt);
      if (inc_r && !m_empty) m_rd = (m_rd + 1) % PMOD;
      m_cnt   = (m_w2 + PMOD - m_rd) % PMOD;
      m_empty = (m_cnt == 0);
      m_w2    = m_w1;
      m_w1    = wcnt;
      check_all($sformatf("rand%0d", c), m_rd, m_cnt, m_empty, (m_cnt <= AEL));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
